// File: rtl/alu_reg_display.sv
// alu_reg_display
//   Registered N-bit ALU whose latched result is shown in hex on a
//   time-multiplexed 4-digit 7-segment display. The flags go to LEDs.
//
//   Operands A/B and the opcode are captured from the shared data_in bus by
//   independent load strobes. updateRes latches ALU(A,B,Op) using the
//   register values held before that edge.
//
//   Optional feature: define ALU_EXT_OPS_EN to widen the opcode to 3 bits:
//     100 A^B, 101 ~(A|B), 110 A<<1, 111 A>>1 (logical).
//
// Parameters
//   N        operand/result width (>= 16; only the low 16 bits are displayed)
//   SCAN_DIV clocks per displayed digit before the scan advances
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   load_A     capture data_in into A
//   load_B     capture data_in into B
//   load_Op    capture data_in[OPW-1:0] into the opcode register
//   updateRes  latch the ALU result and flags
//   data_in    shared operand/opcode bus
//   Segments   {g,f,e,d,c,b,a}, active-low
//   Anodes     digit enables, active-low, exactly one low
//   LEDs       {N,Z,C,V} of the latched result
module alu_reg_display #(
  parameter int N        = 16,
  parameter int SCAN_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_A,
  input  logic         load_B,
  input  logic         load_Op,
  input  logic         updateRes,
  input  logic [N-1:0] data_in,
  output logic [6:0]   Segments,
  output logic [3:0]   Anodes,
  output logic [3:0]   LEDs
);

`ifdef ALU_EXT_OPS_EN
  localparam int OPW = 3;
`else
  localparam int OPW = 2;
`endif
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [N-1:0]   a_q, b_q, res_q, res_d;
  logic [OPW-1:0] op_q;
  logic [3:0]     flags_q, flags_d;
  logic [CW-1:0]  scan_q;
  logic [1:0]     dig_q;
  logic           c_d, v_d;
  logic [N:0]     sum;
  logic [3:0]     nib;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // ALU on the currently held registers; result is latched by updateRes.
  always_comb begin
    sum   = '0;
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op_q)
      OPW'(0): begin
        // Subtract as A + ~B + 1 so carry-out means "no borrow" (A >= B).
        sum   = {1'b0, a_q} + {1'b0, ~b_q} + (N+1)'(1);
        res_d = sum[N-1:0];
        c_d   = sum[N];
        v_d   = (a_q[N-1] != b_q[N-1]) && (res_d[N-1] != a_q[N-1]);
      end
      OPW'(1): begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        res_d = sum[N-1:0];
        c_d   = sum[N];
        v_d   = (a_q[N-1] == b_q[N-1]) && (res_d[N-1] != a_q[N-1]);
      end
      OPW'(2): res_d = a_q | b_q;
      OPW'(3): res_d = a_q & b_q;
`ifdef ALU_EXT_OPS_EN
      OPW'(4): res_d = a_q ^ b_q;
      OPW'(5): res_d = ~(a_q | b_q);
      OPW'(6): begin
        res_d = {a_q[N-2:0], 1'b0};
        c_d   = a_q[N-1];
      end
      OPW'(7): begin
        res_d = {1'b0, a_q[N-1:1]};
        c_d   = a_q[0];
      end
`endif
      default: res_d = '0;
    endcase
    flags_d = {res_d[N-1], (res_d == '0), c_d, v_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      scan_q  <= '0;
      dig_q   <= '0;
    end else begin
      if (load_A)    a_q  <= data_in;
      if (load_B)    b_q  <= data_in;
      if (load_Op)   op_q <= data_in[OPW-1:0];
      if (updateRes) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
      if (scan_q == CW'(SCAN_DIV - 1)) begin
        scan_q <= '0;
        dig_q  <= dig_q + 2'd1;
      end else begin
        scan_q <= scan_q + CW'(1);
      end
    end
  end

  // Anodes and Segments both derive from the registered digit index, so they
  // switch together and exactly one anode is ever low.
  always_comb begin
    case (dig_q)
      2'd0:    nib = res_q[3:0];
      2'd1:    nib = res_q[7:4];
      2'd2:    nib = res_q[11:8];
      default: nib = res_q[15:12];
    endcase
  end

  assign Anodes   = ~(4'b0001 << dig_q);
  assign Segments = hex_glyph(nib);
  assign LEDs     = flags_q;

endmodule

// File: tb/tb_alu_reg_display.sv
module tb_alu_reg_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        la, lb, lo, ur;
  logic [15:0] din;
  logic [6:0]  Segments;
  logic [3:0]  Anodes;
  logic [3:0]  LEDs;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] m_a, m_b, m_res;
  logic [2:0]  m_op;
  logic [3:0]  m_flg;
  int          m_dig;
  logic [6:0]  glyph [16];

  alu_reg_display #(.N(16), .SCAN_DIV(1)) dut (
    .clk(clk), .reset(reset), .load_A(la), .load_B(lb), .load_Op(lo),
    .updateRes(ur), .data_in(din), .Segments(Segments), .Anodes(Anodes),
    .LEDs(LEDs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sx16(input int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  // Result and flags from plain integer arithmetic.
  task automatic alu_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                           output logic [15:0] r, output logic [3:0] f);
    int unsigned ua, ub, full;
    int s;
    logic c, v;
    ua = a; ub = b; c = 0; v = 0; full = 0;
    case (op)
      3'd0: begin full = (ua + 65536 - ub) % 65536; c = (ua >= ub);
                  s = sx16(ua) - sx16(ub); v = (s > 32767) || (s < -32768); end
      3'd1: begin full = (ua + ub) % 65536; c = (ua + ub) > 65535;
                  s = sx16(ua) + sx16(ub); v = (s > 32767) || (s < -32768); end
      3'd2: full = ua | ub;
      3'd3: full = ua & ub;
      3'd4: full = ua ^ ub;
      3'd5: full = (~(ua | ub)) & 32'hFFFF;
      3'd6: begin full = (ua * 2) % 65536; c = ua >= 32768; end
      default: begin full = ua / 2; c = ua % 2; end
    endcase
    r = full[15:0];
    f = {r[15], r == 16'h0, c, v};
  endtask

  task automatic check_outputs();
    check("anode", {28'h0, Anodes}, {28'h0, ~(4'b0001 << m_dig)});
    check("onelow", $countones(~Anodes), 1);
    check("seg", {25'h0, Segments}, {25'h0, glyph[m_res[4*m_dig +: 4]]});
    check("led", {28'h0, LEDs}, {28'h0, m_flg});
  endtask

  task automatic tick(input logic ia, input logic ib, input logic io, input logic iu,
                      input logic [15:0] d);
    la = ia; lb = ib; lo = io; ur = iu; din = d;
    @(posedge clk);
    if (iu) alu_model(m_a, m_b, m_op, m_res, m_flg);
    if (ia) m_a = d;
    if (ib) m_b = d;
`ifdef ALU_EXT_OPS_EN
    if (io) m_op = d[2:0];
`else
    if (io) m_op = {1'b0, d[1:0]};
`endif
    m_dig = (m_dig + 1) % 4;
    @(negedge clk);
    check_outputs();
  endtask

  // Reads the four displayed digits back into a 16-bit value.
  task automatic read_disp(output logic [15:0] v);
    int k;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 16'h0);
      k = 0;
      for (int j = 0; j < 4; j++) if (!Anodes[j]) k = j;
      for (int h = 0; h < 16; h++) if (glyph[h] == Segments) v[4*k +: 4] = h[3:0];
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flg = 0; m_dig = 0;
  endtask

  logic [15:0] v;

  initial begin
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    model_reset();
    reset = 1'b0; la = 0; lb = 0; lo = 0; ur = 0; din = 0;
    #1;
    check("rst_anode", {28'h0, Anodes}, 32'hE);
    check("rst_seg", {25'h0, Segments}, 32'h40);
    check("rst_led", {28'h0, LEDs}, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_hold_anode", {28'h0, Anodes}, 32'hE);
    reset = 1'b1;

    // scan walks 1101, 1011, 0111, 1110
    tick(0, 0, 0, 0, 0); check("scan1", {28'h0, Anodes}, 32'hD);
    tick(0, 0, 0, 0, 0); check("scan2", {28'h0, Anodes}, 32'hB);
    tick(0, 0, 0, 0, 0); check("scan3", {28'h0, Anodes}, 32'h7);
    tick(0, 0, 0, 0, 0); check("scan0", {28'h0, Anodes}, 32'hE);

    // add
    tick(1, 0, 0, 0, 16'h1234); tick(0, 1, 0, 0, 16'h0FFF); tick(0, 0, 1, 0, 16'h0001);
    tick(0, 0, 0, 1, 16'h0);
    check("add_led", {28'h0, LEDs}, 32'h0);
    read_disp(v); check("add_res", {16'h0, v}, 32'h2233);

    // sub with borrow
    tick(1, 0, 0, 0, 16'h0001); tick(0, 1, 0, 0, 16'h0002); tick(0, 0, 1, 0, 16'h0000);
    tick(0, 0, 0, 1, 16'h0);
    check("sub_led", {28'h0, LEDs}, 32'h8);
    read_disp(v); check("sub_res", {16'h0, v}, 32'hFFFF);

    // signed overflow
    tick(1, 0, 0, 0, 16'h7FFF); tick(0, 1, 0, 0, 16'h0001); tick(0, 0, 1, 0, 16'h0001);
    tick(0, 0, 0, 1, 16'h0);
    check("ovf_led", {28'h0, LEDs}, 32'h9);
    read_disp(v); check("ovf_res", {16'h0, v}, 32'h8000);

    // zero result; upper bus bits on load_Op are ignored
    tick(1, 1, 0, 0, 16'h00F0); tick(0, 0, 1, 0, 16'hFFF0);
    tick(0, 0, 0, 1, 16'h0);
    check("zero_led", {28'h0, LEDs}, 32'h6);

    // load together with updateRes uses the old A
    tick(1, 0, 0, 0, 16'h0003); tick(0, 1, 0, 0, 16'h0001); tick(0, 0, 1, 0, 16'h0001);
    tick(1, 0, 0, 1, 16'h0005);
    read_disp(v); check("simul_old", {16'h0, v}, 32'h0004);
    tick(0, 0, 0, 1, 16'h0);
    read_disp(v); check("simul_new", {16'h0, v}, 32'h0006);

    // asynchronous reset in mid-cycle
    #2 reset = 1'b0;
    #1;
    check("arst_anode", {28'h0, Anodes}, 32'hE);
    check("arst_seg", {25'h0, Segments}, 32'h40);
    check("arst_led", {28'h0, LEDs}, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(0, 0, 0, 0, 0); check("arst_scan", {28'h0, Anodes}, 32'hD);

    // random stress
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  s;
      logic [15:0] d;
      s = 4'($urandom);
      case ($urandom_range(0, 3))
        0: d = 16'h0000;
        1: d = 16'h8000 ^ 16'($urandom_range(0, 3));
        default: d = 16'($urandom);
      endcase
      tick(s[0], s[1], s[2], s[3], d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
